// File: rtl/sprite_line_fetch.sv
// sprite_line_fetch
//
// Prefetches one row of a W x H, 8-bit-index sprite into a local line buffer
// during horizontal blank, then serves palette indices per DrawX during
// active video. The ROM port is only used during the fetch, so other
// fetchers can share the ROM for the rest of the line.
//
// Optional feature: define SPRITE_MIRROR_EN to add the 'flip' input
// (horizontal mirror, latched at line_start).
//
// Ports:
//   Clk          system clock, all logic on posedge
//   Reset_n      synchronous active-low reset
//   line_start   one-cycle pulse at start of hblank preceding line next_y
//   next_y       scanline about to be displayed
//   sprite_x/y   sprite top-left position (screen pixels)
//   DrawX        current pixel column
//   rom_addr     sprite ROM read address (0 when not fetching)
//   rom_data     ROM read data, valid one cycle after rom_addr
//   busy         fetch in progress
//   pixel_valid  opaque sprite pixel at the DrawX presented last cycle
//   pixel_idx    palette index, 0 when pixel_valid is 0
//   flip         mirror horizontally (SPRITE_MIRROR_EN only)

module sprite_line_fetch #(
    parameter int         W           = 32,
    parameter int         H           = 32,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        line_start,
    input  logic [9:0]  next_y,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    input  logic [9:0]  DrawX,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        busy,
    output logic        pixel_valid,
    output logic [7:0]  pixel_idx
`ifdef SPRITE_MIRROR_EN
    ,
    input  logic        flip
`endif
);

    localparam int KW = $clog2(W);
    // W is a power of two, so the last column index is all ones.
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [9:0]    W10    = 10'(W);
    localparam logic [9:0]    H10    = 10'(H);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

    state_t          state, state_next;
    logic [9:0]      row;
    logic [9:0]      x0;
    logic [KW-1:0]   k;
    logic            line_active;
    logic [7:0]      line_buf [W];

    logic [9:0]      row_new;
    logic            buf_we;
    logic [KW-1:0]   buf_waddr;

    logic [9:0]      col;
    logic [KW-1:0]   rd_idx;
    logic [7:0]      rd_data;

`ifdef SPRITE_MIRROR_EN
    logic            flip_q;
`endif

    // Wrapped difference: rows above the sprite land far above H.
    assign row_new = next_y - sprite_y;

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and fetch outputs. While fetching, the data arriving this
    // cycle belongs to the address issued last cycle (k-1). A line_start
    // overrides everything and suppresses the buffer write, which drops
    // the in-flight word of an aborted fetch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        rom_addr   = 16'd0;
        buf_we     = 1'b0;
        buf_waddr  = k - K_ONE;
        case (state)
            IDLE: begin
            end
            FETCH: begin
                busy     = 1'b1;
                rom_addr = 16'(row) * 16'(W) + 16'(k);
                buf_we   = (k != '0);
                if (k == K_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                buf_we     = 1'b1;
                buf_waddr  = K_LAST;
                state_next = READY;
            end
            READY: begin
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (line_start) begin
            buf_we     = 1'b0;
            state_next = (row_new < H10) ? FETCH : IDLE;
        end
    end

    // Per-line context: row, X origin and column counter are latched at
    // line_start, so later sprite_x/sprite_y changes cannot tear the line.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            row         <= '0;
            x0          <= '0;
            k           <= '0;
            line_active <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            flip_q      <= 1'b0;
`endif
        end else if (line_start) begin
            row         <= row_new;
            x0          <= sprite_x;
            k           <= '0;
            line_active <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            flip_q      <= flip;
`endif
        end else begin
            if (state == FETCH) begin
                k <= k + K_ONE;
            end
            if (state == DRAIN) begin
                line_active <= 1'b1;
            end
        end
    end

    // Line buffer, contents are meaningless until line_active.
    always_ff @(posedge Clk) begin
        if (buf_we) begin
            line_buf[buf_waddr] <= rom_data;
        end
    end

    // Pixel lookup: columns left of the sprite wrap to large values and
    // fail the col < W test along with columns right of it.
    assign col = DrawX - x0;
`ifdef SPRITE_MIRROR_EN
    assign rd_idx = flip_q ? (K_LAST - col[KW-1:0]) : col[KW-1:0];
`else
    assign rd_idx = col[KW-1:0];
`endif
    assign rd_data = line_buf[rd_idx];

    // Registered pixel output, one cycle after DrawX.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pixel_valid <= 1'b0;
            pixel_idx   <= 8'd0;
        end else if (line_active && (col < W10) && (rd_data != TRANSPARENT)) begin
            pixel_valid <= 1'b1;
            pixel_idx   <= rd_data;
        end else begin
            pixel_valid <= 1'b0;
            pixel_idx   <= 8'd0;
        end
    end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Testbench for sprite_line_fetch: a behavioural ROM plus a line-level
// reference model (whole sprite row copied at line_start, pixel rule
// applied with plain arithmetic). Build with SPRITE_MIRROR_EN defined to
// also exercise the flip port.

module tb_sprite_line_fetch;

    localparam int W = 32;
    localparam int H = 32;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        line_start;
    logic [9:0]  next_y, sprite_x, sprite_y, DrawX;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        busy, pixel_valid;
    logic [7:0]  pixel_idx;
`ifdef SPRITE_MIRROR_EN
    logic        flip;
`endif

    logic [7:0]  rom_mem [1024];

    // Reference model of the currently displayed line.
    logic        m_line_ok;
    logic [9:0]  m_x0;
    logic        m_flip;
    logic [7:0]  m_line [W];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    // Synchronous ROM, one-cycle read latency.
    always @(posedge Clk) rom_data <= rom_mem[rom_addr[9:0]];

    sprite_line_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .line_start  (line_start),
        .next_y      (next_y),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .DrawX       (DrawX),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .busy        (busy),
        .pixel_valid (pixel_valid),
        .pixel_idx   (pixel_idx)
`ifdef SPRITE_MIRROR_EN
        ,
        .flip        (flip)
`endif
    );

    // Expected {valid, idx} for a column, from the model line.
    function automatic logic [8:0] model_pixel(input logic [9:0] dx);
        logic [9:0] c;
        logic [7:0] v;
        c = dx - m_x0;
        if (!m_line_ok || c >= 10'(W)) return 9'h000;
        v = m_flip ? m_line[W - 1 - int'(c)] : m_line[int'(c)];
        if (v == 8'h00) return 9'h000;
        return {1'b1, v};
    endfunction

    task automatic fill_rom_linear();
        for (int a = 0; a < 1024; a++) rom_mem[a] = 8'(a);
    endtask

    task automatic fill_rom_random();
        for (int a = 0; a < 1024; a++)
            rom_mem[a] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    endtask

    // Pulses line_start for one cycle and loads the model line.
    // Returns at the negedge right after the line_start edge.
    task automatic start_line(input logic [9:0] ny, input logic [9:0] sy,
                              input logic [9:0] sx, input logic fl);
        logic [9:0] r;
        @(negedge Clk);
        next_y   = ny;
        sprite_y = sy;
        sprite_x = sx;
`ifdef SPRITE_MIRROR_EN
        flip     = fl;
`endif
        line_start = 1'b1;
        r = ny - sy;
        m_line_ok = (r < 10'(H));
        m_x0      = sx;
        m_flip    = fl;
        for (int i = 0; i < W; i++) m_line[i] = rom_mem[(int'(r) * W + i) % 1024];
        @(negedge Clk);
        line_start = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        line_start = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (rom_addr !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pixel_valid: got %b expected 0", pixel_valid); end
        n_checks++; if (pixel_idx !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_pixel_idx: got %h expected 00", pixel_idx); end
        Reset_n = 1'b1;
        m_line_ok = 1'b0;
        @(negedge Clk);
    endtask

    // Row 5 of a linear ROM: addresses 160..191, busy for 33 cycles.
    task automatic test_fetch();
        fill_rom_linear();
        DrawX = 10'd200;
        start_line(10'd105, 10'd100, 10'd200, 1'b0);
        for (int i = 0; i <= W; i++) begin
            if (i > 0) @(negedge Clk);
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL fetch_busy[%0d]: got %b expected 1", i, busy); end
            n_checks++;
            if (rom_addr !== ((i < W) ? 16'(160 + i) : 16'd0)) begin
                n_fail++; $display("[TB] FAIL fetch_addr[%0d]: got %0d expected %0d", i, rom_addr, (i < W) ? 160 + i : 0);
            end
        end
        @(negedge Clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_busy_end: got %b expected 0", busy); end
        n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_not_yet_active: got %b expected 0", pixel_valid); end
        @(negedge Clk);
        n_checks++; if ({pixel_valid, pixel_idx} !== 9'h1A0) begin
            n_fail++; $display("[TB] FAIL fetch_first_pixel: got %b/%h expected 1/a0", pixel_valid, pixel_idx);
        end
    endtask

    task automatic test_pixel();
        logic [9:0] pts [4];
        logic [8:0] exp;
        pts[0] = 10'd200; pts[1] = 10'd231; pts[2] = 10'd232; pts[3] = 10'd199;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk); DrawX = pts[i];
            @(negedge Clk);
            exp = model_pixel(pts[i]);
            n_checks++;
            if ({pixel_valid, pixel_idx} !== exp) begin
                n_fail++; $display("[TB] FAIL pixel_edge x=%0d: got %b/%h expected %b/%h", pts[i], pixel_valid, pixel_idx, exp[8], exp[7:0]);
            end
        end
        for (int x = 190; x <= 240; x += 3) begin
            @(negedge Clk); DrawX = 10'(x);
            @(negedge Clk);
            exp = model_pixel(10'(x));
            n_checks++;
            if ({pixel_valid, pixel_idx} !== exp) begin
                n_fail++; $display("[TB] FAIL pixel_sweep x=%0d: got %b/%h expected %b/%h", x, pixel_valid, pixel_idx, exp[8], exp[7:0]);
            end
        end
    endtask

    // Row 0 col 0 of a linear ROM is 8'h00 and must be see-through.
    task automatic test_transparent();
        logic [8:0] exp;
        fill_rom_linear();
        start_line(10'd50, 10'd50, 10'd300, 1'b0);
        repeat (34) @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk); DrawX = 10'(300 + i);
            @(negedge Clk);
            exp = model_pixel(10'(300 + i));
            n_checks++;
            if ({pixel_valid, pixel_idx} !== exp) begin
                n_fail++; $display("[TB] FAIL transparent col=%0d: got %b/%h expected %b/%h", i, pixel_valid, pixel_idx, exp[8], exp[7:0]);
            end
        end
    endtask

    // Line above the sprite: wrapped row 1023, no fetch at all.
    task automatic test_offscreen();
        logic [8:0] exp;
        start_line(10'd99, 10'd100, 10'd300, 1'b0);
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (busy !== 1'b0 || rom_addr !== 16'd0) begin
                n_fail++; $display("[TB] FAIL offscreen_idle[%0d]: got busy=%b addr=%0d expected busy=0 addr=0", i, busy, rom_addr);
            end
            @(negedge Clk);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk); DrawX = 10'(300 + i * 9);
            @(negedge Clk);
            exp = model_pixel(DrawX);
            n_checks++;
            if ({pixel_valid, pixel_idx} !== exp) begin
                n_fail++; $display("[TB] FAIL offscreen_pixel x=%0d: got %b/%h expected %b/%h", DrawX, pixel_valid, pixel_idx, exp[8], exp[7:0]);
            end
        end
    endtask

    // Restart 10 cycles into a fetch; the buffer must end up with new-row data only.
    task automatic test_back_to_back();
        logic [8:0] exp;
        fill_rom_random();
        start_line(10'd23, 10'd20, 10'd100, 1'b0);
        repeat (9) @(negedge Clk);
        start_line(10'd27, 10'd20, 10'd100, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge Clk);
            n_checks++;
            if (rom_addr !== 16'(7 * W + i)) begin
                n_fail++; $display("[TB] FAIL restart_addr[%0d]: got %0d expected %0d", i, rom_addr, 7 * W + i);
            end
        end
        repeat (3) @(negedge Clk);
        for (int c = 0; c < W; c++) begin
            @(negedge Clk); DrawX = 10'(100 + c);
            @(negedge Clk);
            exp = model_pixel(DrawX);
            n_checks++;
            if ({pixel_valid, pixel_idx} !== exp) begin
                n_fail++; $display("[TB] FAIL restart_buf col=%0d: got %b/%h expected %b/%h", c, pixel_valid, pixel_idx, exp[8], exp[7:0]);
            end
        end
    endtask

    // Random positions, including left-edge wrap, with sprite_x/sprite_y
    // scrambled after line_start to confirm they are not re-sampled.
    task automatic test_random();
        logic [9:0] sy, sx, ny, dx;
        logic       fl;
        logic [8:0] exp;
        for (int n = 0; n < 8; n++) begin
            fill_rom_random();
            sy = 10'($urandom_range(0, 479));
            ny = sy + 10'($urandom_range(0, 40));
            sx = (n == 0) ? 10'd1016 : 10'($urandom_range(0, 1023));
            fl = 1'b0;
`ifdef SPRITE_MIRROR_EN
            fl = 1'($urandom_range(0, 1));
`endif
            start_line(ny, sy, sx, fl);
            repeat (34) @(negedge Clk);
            for (int j = 0; j < 24; j++) begin
                @(negedge Clk);
                dx = (n == 0 && j < 8) ? 10'(j) : sx - 10'd4 + 10'($urandom_range(0, 40));
                DrawX    = dx;
                sprite_x = 10'($urandom_range(0, 1023));
                sprite_y = 10'($urandom_range(0, 1023));
                @(negedge Clk);
                exp = model_pixel(dx);
                n_checks++;
                if ({pixel_valid, pixel_idx} !== exp) begin
                    n_fail++; $display("[TB] FAIL random line=%0d x=%0d: got %b/%h expected %b/%h", n, dx, pixel_valid, pixel_idx, exp[8], exp[7:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        fill_rom_random();
        rom_mem[2] = 8'h5A;
        start_line(10'd60, 10'd60, 10'd50, 1'b0);
        repeat (34) @(negedge Clk);
        DrawX = 10'd52;
        @(negedge Clk);
        n_checks++; if ({pixel_valid, pixel_idx} !== 9'h15A) begin
            n_fail++; $display("[TB] FAIL pre_reset_pixel: got %b/%h expected 1/5a", pixel_valid, pixel_idx);
        end
        Reset_n = 1'b0;
        @(negedge Clk);
        n_checks++; if ({pixel_valid, pixel_idx} !== 9'h000) begin
            n_fail++; $display("[TB] FAIL reset_ready_pixel: got %b/%h expected 0/00", pixel_valid, pixel_idx);
        end
        Reset_n = 1'b1;
        m_line_ok = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++; if (pixel_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_line_inactive: got %b expected 0", pixel_valid);
        end
        start_line(10'd61, 10'd60, 10'd50, 1'b0);
        repeat (5) @(negedge Clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL midfetch_busy: got %b expected 1", busy); end
        Reset_n = 1'b0;
        @(negedge Clk);
        n_checks++; if (busy !== 1'b0 || rom_addr !== 16'd0 || pixel_valid !== 1'b0 || pixel_idx !== 8'd0) begin
            n_fail++; $display("[TB] FAIL midfetch_reset: got busy=%b addr=%0d valid=%b idx=%h expected 0/0/0/00", busy, rom_addr, pixel_valid, pixel_idx);
        end
        Reset_n = 1'b1;
        m_line_ok = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++; if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midfetch_after_reset: got busy=%b valid=%b expected 0/0", busy, pixel_valid);
        end
    endtask

`ifdef SPRITE_MIRROR_EN
    // Row 5 of a linear ROM mirrored: DrawX=sprite_x shows column 31 (8'hBF).
    task automatic test_mirror();
        fill_rom_linear();
        start_line(10'd105, 10'd100, 10'd200, 1'b1);
        repeat (34) @(negedge Clk);
        DrawX = 10'd200;
        @(negedge Clk);
        n_checks++; if ({pixel_valid, pixel_idx} !== 9'h1BF) begin
            n_fail++; $display("[TB] FAIL mirror_col0: got %b/%h expected 1/bf", pixel_valid, pixel_idx);
        end
        DrawX = 10'd231;
        @(negedge Clk);
        n_checks++; if ({pixel_valid, pixel_idx} !== 9'h1A0) begin
            n_fail++; $display("[TB] FAIL mirror_col31: got %b/%h expected 1/a0", pixel_valid, pixel_idx);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Reset_n    = 1'b0;
        line_start = 1'b0;
        next_y     = '0;
        sprite_x   = '0;
        sprite_y   = '0;
        DrawX      = '0;
`ifdef SPRITE_MIRROR_EN
        flip       = 1'b0;
`endif
        m_line_ok  = 1'b0;
        m_x0       = '0;
        m_flip     = 1'b0;
        fill_rom_linear();

        test_reset();
        test_fetch();
        test_pixel();
        test_transparent();
        test_offscreen();
        test_back_to_back();
        test_random();
        test_reset_mid_fetch();
`ifdef SPRITE_MIRROR_EN
        test_mirror();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
